// File: rtl/vmac_pkg.sv
// Shared types and width/saturation helpers for the vec_mac_pipe datapath.
package vmac_pkg;

  localparam int unsigned MaxAccW = 64;

  typedef logic [MaxAccW-1:0] lim_t;

  // Per-stage valid bit plus the sideband that travels with each beat.
  typedef struct packed {
    logic valid;
    logic last;
    logic sgn;
  } stage_ctl_t;

  function automatic int unsigned sum_width(input int unsigned w, input int unsigned lanes);
    return 2 * w + $clog2(lanes) + 1;
  endfunction

  function automatic lim_t umax(input int unsigned w);
    return {MaxAccW{1'b1}} >> (MaxAccW - w);
  endfunction

  function automatic lim_t smax(input int unsigned w);
    return umax(w - 1);
  endfunction

  // Only the low w bits are meaningful; callers truncate to their width.
  function automatic lim_t smin(input int unsigned w);
    return lim_t'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/vec_mac_pipe_if.sv
// Beat-in / result-out handshake bundle for vec_mac_pipe.
interface vec_mac_pipe_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic                 in_sgn;
  logic [LANES*W-1:0]   a;
  logic [LANES*W-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic                 out_of;

  modport master (
    output in_valid, in_last, in_sgn, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_of
  );

  modport slave (
    input  in_valid, in_last, in_sgn, a, b, out_ready,
    output in_ready, out_valid, out_data, out_of
  );

endinterface

// File: rtl/vmac_lane_mul.sv
// One lane's registered W x W multiplier; sgn_i selects two's-complement operands.
module vmac_lane_mul #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           sgn_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] prod_d;
  logic [2*W-1:0] prod_q;

  always_comb begin
    a_ext  = {{W{sgn_i & a_i[W-1]}}, a_i};
    b_ext  = {{W{sgn_i & b_i[W-1]}}, b_i};
    // Low 2W bits of the extended product are exact in both modes.
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/vec_mac_pipe.sv
// Four-stage multi-lane saturating dot-product MAC.
// Define VMAC_SIGNED_EN to honour in_sgn (signed multiply, sign-extending tree, signed clamps).
module vec_mac_pipe
  import vmac_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
) (
  input logic           clk,
  input logic           r,
  vec_mac_pipe_if.slave bus
);

`ifdef VMAC_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  localparam int unsigned ProdW = 2 * W;
  localparam int unsigned SumW  = sum_width(W, LANES);

  localparam logic [ACC_W-1:0] UMax = ACC_W'(umax(ACC_W));
  localparam logic [ACC_W-1:0] SMax = ACC_W'(smax(ACC_W));
  localparam logic [ACC_W-1:0] SMin = ACC_W'(smin(ACC_W));

  if (ACC_W < SumW) begin : g_bad_acc_w
    $error("vec_mac_pipe: ACC_W must be at least 2*W + clog2(LANES) + 1");
  end
  if (ACC_W > MaxAccW) begin : g_too_wide
    $error("vec_mac_pipe: ACC_W exceeds the saturation helper width");
  end
  if (LANES == 0 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("vec_mac_pipe: LANES must be a power of two");
  end

  // Whole pipeline moves together; it only stalls behind an untaken result.
  logic adv;
  logic out_valid_q, out_valid_d;
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // S1: operand register
  stage_ctl_t         s1_q;
  logic [LANES*W-1:0] a_q;
  logic [LANES*W-1:0] b_q;

  always_ff @(posedge clk) begin
    if (r) begin
      s1_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (adv) begin
      s1_q <= '{valid: bus.in_valid, last: bus.in_last, sgn: bus.in_sgn};
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  // S2: per-lane products
  stage_ctl_t       s2_q;
  logic [ProdW-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vmac_lane_mul #(
      .W(W)
    ) u_mul (
      .clk_i (clk),
      .rst_i (r),
      .en_i  (adv),
      .sgn_i (SignedEn && s1_q.sgn),
      .a_i   (a_q[i*W +: W]),
      .b_i   (b_q[i*W +: W]),
      .prod_o(prod[i])
    );
  end

  always_ff @(posedge clk) begin
    if (r) begin
      s2_q <= '0;
    end else if (adv) begin
      s2_q <= s1_q;
    end
  end

  // S3: heap-ordered adder tree; leaves at [LANES..2*LANES-1], root at [1].
  stage_ctl_t      s3_q;
  logic [SumW-1:0] sum_q;
  logic [SumW-1:0] node [1:2*LANES-1];
  logic            s2_sgn;

  assign s2_sgn = SignedEn && s2_q.sgn;

  always_comb begin
    for (int i = 1; i < 2 * int'(LANES); i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      node[LANES + i] = {{(SumW - ProdW){s2_sgn & prod[i][ProdW-1]}}, prod[i]};
    end
    for (int i = int'(LANES) - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      s3_q  <= '0;
      sum_q <= '0;
    end else if (adv) begin
      s3_q  <= s2_q;
      sum_q <= node[1];
    end
  end

  // S4: accumulate with saturation, emit on last
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_of_q, out_of_d;
  logic             s3_sgn;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   tot;
  logic             ovf;
  logic [ACC_W-1:0] res;

  always_comb begin
    s3_sgn  = SignedEn && s3_q.sgn;
    acc_ext = {s3_sgn & acc_q[ACC_W-1], acc_q};
    sum_ext = {{(ACC_W + 1 - SumW){s3_sgn & sum_q[SumW-1]}}, sum_q};
    tot     = acc_ext + sum_ext;
    ovf     = s3_sgn ? (tot[ACC_W] ^ tot[ACC_W-1]) : tot[ACC_W];
    // A vector that already clamped stays pinned at its clamp value.
    if (sticky_q) begin
      res = acc_q;
    end else if (ovf) begin
      res = s3_sgn ? (tot[ACC_W] ? SMin : SMax) : UMax;
    end else begin
      res = tot[ACC_W-1:0];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_of_d    = out_of_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (s3_q.valid) begin
        if (s3_q.last) begin
          out_valid_d = 1'b1;
          out_data_d  = res;
          out_of_d    = sticky_q | ovf;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = res;
          sticky_d = sticky_q | ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_of_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_of_q    <= out_of_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_of    = out_of_q;

endmodule

// File: tb/tb_vec_mac_pipe.sv
// Directed bench driving two vec_mac_pipe instances (ACC_W 24 and 19) in lockstep.
module tb_vec_mac_pipe;

  logic        clk = 1'b0;
  logic        r;
  logic        vld, lst, sgn, rdy;
  logic [31:0] a_v, b_v;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  vec_mac_pipe_if #(.W(8), .LANES(4), .ACC_W(24)) bus24 ();
  vec_mac_pipe_if #(.W(8), .LANES(4), .ACC_W(19)) bus19 ();

  assign bus24.in_valid  = vld;
  assign bus24.in_last   = lst;
  assign bus24.in_sgn    = sgn;
  assign bus24.a         = a_v;
  assign bus24.b         = b_v;
  assign bus24.out_ready = rdy;
  assign bus19.in_valid  = vld;
  assign bus19.in_last   = lst;
  assign bus19.in_sgn    = sgn;
  assign bus19.a         = a_v;
  assign bus19.b         = b_v;
  assign bus19.out_ready = rdy;

  vec_mac_pipe #(.W(8), .LANES(4), .ACC_W(24)) u_dut24 (
    .clk(clk),
    .r  (r),
    .bus(bus24)
  );

  vec_mac_pipe #(.W(8), .LANES(4), .ACC_W(19)) u_dut19 (
    .clk(clk),
    .r  (r),
    .bus(bus19)
  );

  function automatic logic [31:0] lanes4(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [31:0] spl(input int x);
    return lanes4(x, x, x, x);
  endfunction

  function automatic logic [31:0] m24(input int v);
    return 32'(v) & 32'h00FF_FFFF;
  endfunction

  function automatic logic [31:0] m19(input int v);
    return 32'(v) & 32'h0007_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic last,
                      input logic s);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    vld  = 1'b1;
    a_v  = av;
    b_v  = bv;
    lst  = last;
    sgn  = s;
    do begin
      took = bus24.in_ready;
      step();
      n++;
    end while (!took && n < 20);
    check_val("accept", 32'(took), 32'd1);
    vld = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus24.out_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] e24, input logic of24,
                           input logic [31:0] e19, input logic of19);
    check_val({tag, "_v24"}, 32'(bus24.out_valid), 32'd1);
    check_val({tag, "_v19"}, 32'(bus19.out_valid), 32'd1);
    check_val({tag, "_d24"}, 32'(bus24.out_data), e24);
    check_val({tag, "_d19"}, 32'(bus19.out_data), e19);
    check_val({tag, "_of24"}, 32'(bus24.out_of), 32'(of24));
    check_val({tag, "_of19"}, 32'(bus19.out_of), 32'(of19));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    r   = 1'b1;
    vld = 1'b0;
    lst = 1'b0;
    sgn = 1'b0;
    rdy = 1'b1;
    a_v = '0;
    b_v = '0;
    step();
    step();
    r = 1'b0;
    check_val("rst_ovalid", 32'(bus24.out_valid), 32'd0);
    check_val("rst_iready", 32'(bus24.in_ready), 32'd1);
    check_val("rst_data", 32'(bus24.out_data), 32'd0);
    check_val("rst_of", 32'(bus24.out_of), 32'd0);
    check_val("rst_ovalid19", 32'(bus19.out_valid), 32'd0);

    // Single last beat: 4 x (3*5) = 60, visible after the fourth edge
    send(spl(3), spl(5), 1'b1, 1'b0);
    check_val("lat_e0", 32'(bus24.out_valid), 32'd0);
    step();
    step();
    check_val("lat_e2", 32'(bus24.out_valid), 32'd0);
    step();
    check_res("lat_e3", 32'd60, 1'b0, 32'd60, 1'b0);
    step();
    check_val("lat_drain", 32'(bus24.out_valid), 32'd0);

    // Three beats of (1+2+3+4) = 30, then a fresh 1-beat vector = 4
    send(lanes4(1, 2, 3, 4), spl(1), 1'b0, 1'b0);
    send(lanes4(1, 2, 3, 4), spl(1), 1'b0, 1'b0);
    send(lanes4(1, 2, 3, 4), spl(1), 1'b1, 1'b0);
    wait_out();
    check_res("vec3", 32'd30, 1'b0, 32'd30, 1'b0);
    send(spl(1), spl(1), 1'b1, 1'b0);
    wait_out();
    check_res("vec1", 32'd4, 1'b0, 32'd4, 1'b0);

    // Unsigned saturation: 3 x 260100 = 780300 exceeds 2^19-1
    send(spl(255), spl(255), 1'b0, 1'b0);
    send(spl(255), spl(255), 1'b0, 1'b0);
    send(spl(255), spl(255), 1'b1, 1'b0);
    wait_out();
    check_res("usat", 32'd780300, 1'b0, 32'd524287, 1'b1);
    send(spl(1), spl(1), 1'b1, 1'b0);
    wait_out();
    check_res("usat_clean", 32'd4, 1'b0, 32'd4, 1'b0);

`ifdef VMAC_SIGNED_EN
    // Signed: each beat is 4 x (-128*127) = -65024
    for (int i = 0; i < 5; i++) begin
      send(spl(-128), spl(127), (i == 4), 1'b1);
    end
    wait_out();
    check_res("ssat5", m24(-325120), 1'b0, m19(-262144), 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(spl(-128), spl(127), (i == 3), 1'b1);
    end
    wait_out();
    check_res("ssat4", m24(-260096), 1'b0, m19(-260096), 1'b0);
`else
    // in_sgn ignored: 0x80 * 0x7F read unsigned, 4 x 16256
    send(spl(128), spl(127), 1'b1, 1'b1);
    wait_out();
    check_res("sgn_ignored", 32'd65024, 1'b0, 32'd65024, 1'b0);
`endif

    // Back-to-back one-element vectors land on consecutive cycles
    send(spl(1), spl(1), 1'b1, 1'b0);
    send(spl(1), spl(2), 1'b1, 1'b0);
    wait_out();
    check_res("b2b_a", 32'd4, 1'b0, 32'd4, 1'b0);
    step();
    check_res("b2b_b", 32'd8, 1'b0, 32'd8, 1'b0);
    step();
    check_val("b2b_drain", 32'(bus24.out_valid), 32'd0);

    // Backpressure: four vectors in flight, a fifth waiting at the input
    rdy = 1'b0;
    send(spl(1), spl(1), 1'b1, 1'b0);
    send(spl(2), spl(2), 1'b1, 1'b0);
    send(spl(3), spl(3), 1'b1, 1'b0);
    send(spl(3), spl(5), 1'b1, 1'b0);
    vld = 1'b1;
    a_v = spl(1);
    b_v = spl(1);
    lst = 1'b1;
    sgn = 1'b0;
    step();
    step();
    check_val("stall_iready", 32'(bus24.in_ready), 32'd0);
    check_res("stall_hold", 32'd4, 1'b0, 32'd4, 1'b0);
    rdy = 1'b1;
    step();
    vld = 1'b0;
    check_res("drain_b", 32'd16, 1'b0, 32'd16, 1'b0);
    step();
    check_res("drain_c", 32'd36, 1'b0, 32'd36, 1'b0);
    step();
    check_res("drain_d", 32'd60, 1'b0, 32'd60, 1'b0);
    step();
    check_res("drain_e", 32'd4, 1'b0, 32'd4, 1'b0);
    step();
    check_val("drain_end", 32'(bus24.out_valid), 32'd0);

    // Reset mid-vector discards the partial sum and in-flight beats
    send(spl(3), spl(5), 1'b0, 1'b0);
    send(spl(3), spl(5), 1'b0, 1'b0);
    r = 1'b1;
    step();
    r = 1'b0;
    check_val("midrst_ovalid", 32'(bus24.out_valid), 32'd0);
    send(spl(2), spl(2), 1'b1, 1'b0);
    wait_out();
    check_res("midrst", 32'd16, 1'b0, 32'd16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mac_pipe.md
# vec_mac_pipe

Parametrised, pipelined multi-lane multiply-accumulate engine: the successor to the single-lane 8-bit saturating MAC. Each accepted beat carries LANES operand pairs. The pipeline multiplies each pair, sums the products in an adder tree, and accumulates the sum into a wide saturating accumulator. A beat flagged `in_last` closes a vector: its dot product is emitted on a valid/ready output and the accumulator clears. It sits between operand-streaming logic and downstream result consumers in the vector datapath.

## Interface
- `W`, 8: operand width per lane.
- `LANES`, 4: operand pairs per beat; power of two, ≥1.
- `ACC_W`, 24: accumulator/result width; must satisfy ACC_W ≥ 2·W + $clog2(LANES) + 1 (elaboration-time check).

- `clk` in 1: single clock, rising edge.
- `r` in 1: reset, synchronous, active-high.
- `in_valid` in 1: beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `in_last` in 1: beat is the final beat of a vector.
- `in_sgn` in 1: operands are two's complement (see Configuration).
- `a` in LANES·W: packed operands; lane i = a[i·W +: W].
- `b` in LANES·W: packed operands, same lane mapping as `a`.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes result.
- `out_data` out ACC_W: dot-product result.
- `out_of` out 1: saturation occurred during this vector.

## Operation
- Four stages, each carrying a valid bit plus last/sgn sideband: S1 operand register; S2 per-lane products (2·W); S3 adder-tree sum (2·W+$clog2(LANES)+1); S4 accumulate/output.
- Global advance: adv = !out_valid || out_ready. `in_ready` = adv. When adv=0, every stage, the accumulator and the output hold.
- S4, valid non-last beat: acc ← sat(acc + sum). Valid last beat: out_data ← sat(acc + sum), out_of ← sticky flag OR this add overflowed, out_valid ← 1, acc ← 0, sticky ← 0.
- Invalid beats (bubbles) propagate as valid=0 and leave acc untouched.
- Saturation: unsigned clamps to 2^ACC_W−1. Signed clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1). Once saturated within a vector, acc holds the clamp value and the sticky flag stays set until the last beat.
- Sign mode is sampled per beat. A vector must not mix modes; a mixed-mode vector produces an unspecified result but must not hang.
- out_valid clears on an out_ready handshake when no new last beat reaches S4 in that cycle.
- Reset values: in_ready 1 (after reset), out_valid 0, out_data 0, out_of 0, acc 0, all stage valids 0.

## Timing
- Latency: a beat accepted at edge E0 reaches S4 at edge E3 when adv=1 throughout. A last beat therefore gives out_valid high after E3.
- Throughput is one beat per cycle while out_ready=1 or out_valid=0.
- Simultaneous event: out_valid=1, out_ready=1 and a new last beat arrives at S4. out_data/out_of take the new result and out_valid stays 1, with no lost or duplicated result.
- Back-to-back last beats yield one-element vectors with results on consecutive cycles.
- Reset mid-vector clears the partial accumulation and in-flight beats; the first vector after reset starts from acc=0.

## Configuration
- `VMAC_SIGNED_EN` defined: `in_sgn` honoured, with signed multipliers, sign-extending adder tree and signed clamps.
- Undefined: `in_sgn` ignored, unsigned-only datapath and unsigned clamp; the port remains for interface stability.

## Structure
- Package `vmac_pkg`: a function for sum width from (W, LANES), saturation-limit functions (umax, smax, smin for a given width), and the stage-valid/sideband struct typedef.
- Sub-module `vmac_lane_mul`: one lane's registered multiplier (S2), W-parametrised with a signed-mode input, instantiated LANES times via generate.

## Test plan
- Reset, then a single last beat with all lanes a=3, b=5 (unsigned, defaults) → out_data=60, out_of=0, out_valid 4 edges after accept.
- 3-beat vector, lanes a=1,2,3,4 and b=1 each beat → out_data=30. The next 1-beat vector a=b=1 → 4, proving the accumulator cleared.
- ACC_W=19, unsigned, all lanes 255×255 for 3 beats → out_data=524287, out_of=1. The following clean vector → out_of=0.
- ACC_W=19, `VMAC_SIGNED_EN`, lanes a=−128, b=127 for 5 beats → out_data=−262144, out_of=1. With 4 beats → −260096, out_of=0.
- Hold out_ready=0 with a result pending while streaming → in_ready=0 and no beat lost. Release → results in order, with the simultaneous drain+new-result case checked.
- Assert r mid-vector after 2 beats, then send a 1-beat vector of a=b=2 → out_data=16, out_of=0.
